calc_queue: RTL and testbench

CALC_QUEUE -- requirements
Module: calc_queue

---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_queue_mem.sv | 30 +++
 rtl/calc_queue.sv | 189 ++++++++++++++++++
 tb/tb_calc_queue.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand queue: op codes, error codes,
// control FSM states and the default entry width.
package calc_pkg;

    localparam int CALC_DATA_W = 8;

    // Queue operation codes presented on queue_op.
    typedef enum logic [1:0] {
        Q_PUSH         = 2'b00,
        Q_SLEEP        = 2'b01,
        Q_GET_AND_PUSH = 2'b10,
        Q_POP          = 2'b11
    } queue_op_e;

    // Error codes reported on err_code.
    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_OVERFLOW  = 2'b01,
        ERR_UNDERFLOW = 2'b10,
        ERR_CALC      = 2'b11
    } err_code_e;

    // Control FSM states: RUN accepts ops, HALT freezes until reset.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/calc_queue_mem.sv
// Operand storage: DEPTH x DATA_W register file, one synchronous write port
// and two asynchronous read ports (queue head and head+1).
module calc_queue_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr0,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port; contents need no reset because validity is tracked by count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata0 = mem_r[raddr0];
    assign rdata1 = mem_r[raddr1];

endmodule

// File: rtl/calc_queue.sv
// Calculator operand queue: circular buffer with head/tail pointers and an
// occupancy counter, guarded by a RUN/HALT FSM that latches the first error.
// Optional feature: define CALC_QUEUE_WATERMARK_EN to add the hwm output
// (maximum occupancy since reset).
module calc_queue
    import calc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = CALC_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             queue_op,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   calc_err,
    output logic [2*DATA_W-1:0]    operands,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   err,
    output logic [1:0]             err_code
`ifdef CALC_QUEUE_WATERMARK_EN
    ,
    output logic [$clog2(DEPTH):0] hwm
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e            state_r, state_s;
    logic [AW-1:0]     head_r, head_s, tail_r, tail_s, head_nxt_s;
    logic [CW-1:0]     count_r, count_s;
    logic              empty_r, full_r, err_r, err_s;
    logic [1:0]        err_code_r, err_code_s;
    logic              we_s;
    logic [DATA_W-1:0] head_data_s, next_data_s;

    assign head_nxt_s = head_r + AW'(1);

    calc_queue_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (we_s),
        .waddr  (tail_r),
        .wdata  (wr_data),
        .raddr0 (head_r),
        .raddr1 (head_nxt_s),
        .rdata0 (head_data_s),
        .rdata1 (next_data_s)
    );

    // Next-state logic: calc_err outranks overflow/underflow; HALT freezes all.
    always_comb begin
        state_s    = state_r;
        head_s     = head_r;
        tail_s     = tail_r;
        count_s    = count_r;
        err_s      = err_r;
        err_code_s = err_code_r;
        we_s       = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (calc_err) begin
                    state_s    = ST_HALT;
                    err_s      = 1'b1;
                    err_code_s = ERR_CALC;
                end else begin
                    case (queue_op)
                        Q_PUSH: begin
                            if (count_r < DEPTH_C) begin
                                we_s    = 1'b1;
                                tail_s  = tail_r + AW'(1);
                                count_s = count_r + CW'(1);
                            end else begin
                                state_s    = ST_HALT;
                                err_s      = 1'b1;
                                err_code_s = ERR_OVERFLOW;
                            end
                        end
                        Q_POP: begin
                            if (count_r >= CW'(1)) begin
                                head_s  = head_r + AW'(1);
                                count_s = count_r - CW'(1);
                            end else begin
                                state_s    = ST_HALT;
                                err_s      = 1'b1;
                                err_code_s = ERR_UNDERFLOW;
                            end
                        end
                        Q_GET_AND_PUSH: begin
                            // When full, tail equals head: the write lands on
                            // the entry being consumed, so this stays legal.
                            if (count_r >= CW'(2)) begin
                                head_s  = head_r + AW'(2);
                                we_s    = 1'b1;
                                tail_s  = tail_r + AW'(1);
                                count_s = count_r - CW'(1);
                            end else begin
                                state_s    = ST_HALT;
                                err_s      = 1'b1;
                                err_code_s = ERR_UNDERFLOW;
                            end
                        end
                        Q_SLEEP: begin
                            state_s = state_r;
                        end
                        default: begin
                            state_s = state_r;
                        end
                    endcase
                end
            end
            ST_HALT: begin
                err_s = 1'b1;
            end
            default: begin
                state_s = ST_HALT;
                err_s   = 1'b1;
            end
        endcase
    end

    // State, pointer, counter and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            head_r     <= AW'(0);
            tail_r     <= AW'(0);
            count_r    <= CW'(0);
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            state_r    <= state_s;
            head_r     <= head_s;
            tail_r     <= tail_s;
            count_r    <= count_s;
            empty_r    <= (count_s == CW'(0));
            full_r     <= (count_s == DEPTH_C);
            err_r      <= err_s;
            err_code_r <= err_code_s;
        end
    end

    // Operand read-out; each half is zero when its entry is not occupied.
    always_comb begin
        operands = {(2 * DATA_W){1'b0}};
        if (count_r >= CW'(1)) begin
            operands[DATA_W-1:0] = head_data_s;
        end else begin
            operands[DATA_W-1:0] = {DATA_W{1'b0}};
        end
        if (count_r >= CW'(2)) begin
            operands[2*DATA_W-1:DATA_W] = next_data_s;
        end else begin
            operands[2*DATA_W-1:DATA_W] = {DATA_W{1'b0}};
        end
    end

    assign count    = count_r;
    assign empty    = empty_r;
    assign full     = full_r;
    assign err      = err_r;
    assign err_code = err_code_r;

`ifdef CALC_QUEUE_WATERMARK_EN
    logic [CW-1:0] hwm_r;

    // Track the highest occupancy seen since reset, same latency as count.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm_r <= CW'(0);
        end else if (count_s > hwm_r) begin
            hwm_r <= count_s;
        end else begin
            hwm_r <= hwm_r;
        end
    end

    assign hwm = hwm_r;
`endif

endmodule

// File: tb/tb_calc_queue.sv
// Self-checking bench for calc_queue (DEPTH=8, DATA_W=8) with a reference
// FIFO model as scoreboard.
module tb_calc_queue;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  queue_op = Q_SLEEP;
    logic [7:0]  wr_data = 8'd0;
    logic        calc_err = 1'b0;
    logic [15:0] operands;
    logic [3:0]  count;
    logic        empty, full, err;
    logic [1:0]  err_code;
`ifdef CALC_QUEUE_WATERMARK_EN
    logic [3:0]  hwm;
`endif

    calc_queue #(.DEPTH(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .queue_op (queue_op),
        .wr_data  (wr_data),
        .calc_err (calc_err),
        .operands (operands),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .err      (err),
        .err_code (err_code)
`ifdef CALC_QUEUE_WATERMARK_EN
        ,
        .hwm      (hwm)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_halt = 1'b0;
    logic [1:0] m_code = 2'b00;
    int         m_hwm  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic [1:0] op, input logic [7:0] d, input logic ce, input logic r);
        if (r) begin
            mq.delete();
            m_halt = 1'b0;
            m_code = 2'b00;
            m_hwm  = 0;
        end else if (!m_halt) begin
            if (ce) begin
                m_halt = 1'b1; m_code = 2'b11;
            end else begin
                case (op)
                    Q_PUSH: begin
                        if (mq.size() < 8) mq.push_back(d);
                        else begin m_halt = 1'b1; m_code = 2'b01; end
                    end
                    Q_POP: begin
                        if (mq.size() >= 1) void'(mq.pop_front());
                        else begin m_halt = 1'b1; m_code = 2'b10; end
                    end
                    Q_GET_AND_PUSH: begin
                        if (mq.size() >= 2) begin
                            void'(mq.pop_front());
                            void'(mq.pop_front());
                            mq.push_back(d);
                        end else begin m_halt = 1'b1; m_code = 2'b10; end
                    end
                    default: ;
                endcase
            end
            if (mq.size() > m_hwm) m_hwm = mq.size();
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] lo, hi;
        lo = (mq.size() >= 1) ? mq[0] : 8'd0;
        hi = (mq.size() >= 2) ? mq[1] : 8'd0;
        check_val({tag, ".count"}, 32'(count), 32'(mq.size()));
        check_val({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        check_val({tag, ".full"}, 32'(full), 32'(mq.size() == 8));
        check_val({tag, ".err"}, 32'(err), 32'(m_halt));
        check_val({tag, ".err_code"}, 32'(err_code), 32'(m_code));
        check_val({tag, ".operands"}, 32'(operands), {16'd0, hi, lo});
`ifdef CALC_QUEUE_WATERMARK_EN
        check_val({tag, ".hwm"}, 32'(hwm), 32'(m_hwm));
`endif
    endtask

    // Drive one cycle, advance the model, compare after the edge.
    task automatic step(input string tag, input logic [1:0] op, input logic [7:0] d,
                        input logic ce = 1'b0, input logic r = 1'b0);
        queue_op = op; wr_data = d; calc_err = ce; rst = r;
        @(posedge clk);
        #1;
        model_update(op, d, ce, r);
        check_outputs(tag);
        queue_op = Q_SLEEP; calc_err = 1'b0; rst = 1'b0;
    endtask

    initial begin
        // Reset overrides a simultaneous PUSH
        @(posedge clk); #1;
        step("rst_push", Q_PUSH, 8'hAA, 1'b0, 1'b1);

        // Push 5, push 3, then get-and-push 8
        step("push5", Q_PUSH, 8'd5);
        step("push3", Q_PUSH, 8'd3);
        check_val("ops_53", 32'(operands), 32'h0000_0305);
        step("gap8", Q_GET_AND_PUSH, 8'd8);
        check_val("ops_08", 32'(operands), 32'h0000_0008);

        // Fill to 8, get-and-push while full, refill, then overflow
        step("rst2", Q_SLEEP, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step("fill", Q_PUSH, 8'(8'd16 + i));
            if (i == 3) step("sleep", Q_SLEEP, 8'hFF);
        end
        step("gap_full", Q_GET_AND_PUSH, 8'd99);
        step("refill", Q_PUSH, 8'd77);
        step("overflow", Q_PUSH, 8'd55);
        check_val("ovf_code", 32'(err_code), 32'd1);
        step("halt_pop", Q_POP, 8'd0);

        // Underflow on POP when empty, later PUSH ignored
        step("rst3", Q_SLEEP, 8'd0, 1'b0, 1'b1);
        step("pop_empty", Q_POP, 8'd0);
        check_val("udf_code", 32'(err_code), 32'd2);
        step("push_halt", Q_PUSH, 8'd7);

        // Underflow on GET_AND_PUSH with one entry
        step("rst4", Q_SLEEP, 8'd0, 1'b0, 1'b1);
        step("push1", Q_PUSH, 8'd42);
        step("gap_short", Q_GET_AND_PUSH, 8'd1);

        // Calc error outranks a PUSH; reset recovers
        step("rst5", Q_SLEEP, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("p3", Q_PUSH, 8'(8'd100 + i));
        step("calc_err", Q_PUSH, 8'd9, 1'b1);
        check_val("calc_code", 32'(err_code), 32'd3);
        step("rst_recover", Q_PUSH, 8'd9, 1'b0, 1'b1);
        step("push_after", Q_PUSH, 8'd11);

        // Wrap: push 6, pop 5, push 6, then get-and-push across the wrap
        step("rst6", Q_SLEEP, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step("w_push", Q_PUSH, 8'(8'd32 + i));
        for (int i = 0; i < 5; i++) step("w_pop", Q_POP, 8'd0);
        for (int i = 0; i < 6; i++) step("w_push2", Q_PUSH, 8'(8'd64 + i));
        step("w_gap1", Q_GET_AND_PUSH, 8'd200);
        step("w_gap2", Q_GET_AND_PUSH, 8'd201);
        while (mq.size() > 0) step("w_drain", Q_POP, 8'd0);

        // Short random run from a fresh reset
        step("rst7", Q_SLEEP, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            logic [1:0] rop;
            rop = (mq.size() < 2) ? Q_PUSH : 2'($urandom_range(0, 3));
            step("rnd", rop, 8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
